// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - pointer, occupancy and status controller for a 16 x 9-bit FIFO array
module fifo_ctrl #(
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic              i_pop,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_waddr,
    output logic              o_mem_re,
    output logic [ADDR_W-1:0] o_mem_raddr,
    output logic [ADDR_W:0]   o_level,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_almost_full,
    output logic              o_almost_empty,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam int            PTR_W   = ADDR_W + 1;
    localparam logic [ADDR_W:0] PTR_ONE = PTR_W'(1);
    localparam logic [ADDR_W:0] AF_THR  = PTR_W'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_THR  = PTR_W'(AE_LEVEL);

    logic [ADDR_W:0] r_wr_ptr;
    logic [ADDR_W:0] r_rd_ptr;
    logic            r_overflow;
    logic            r_underflow;

    logic [ADDR_W:0] w_level;
    logic            w_full;
    logic            w_empty;
    logic            w_push_ok;
    logic            w_pop_ok;
    logic            w_push_drop;
    logic            w_pop_drop;

    // Wrap bit distinguishes full from empty when the low address bits match.
    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                     (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);

    // Enables are gated by reset so the array is never written while held in reset.
    assign w_push_ok   = i_rst_n & i_push & ~i_flush & (~w_full | i_pop);
    assign w_pop_ok    = i_rst_n & i_pop & ~i_flush & ~w_empty;
    assign w_push_drop = i_push & ~i_flush & w_full & ~i_pop;
    assign w_pop_drop  = i_pop & ~i_flush & w_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (i_flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_pop_drop) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign o_mem_we       = w_push_ok;
    assign o_mem_re       = w_pop_ok;
    assign o_mem_waddr    = r_wr_ptr[ADDR_W-1:0];
    assign o_mem_raddr    = r_rd_ptr[ADDR_W-1:0];
    assign o_level        = w_level;
    assign o_full         = w_full;
    assign o_empty        = w_empty;
    assign o_almost_full  = (w_level >= AF_THR);
    assign o_almost_empty = (w_level <= AE_THR);
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - scoreboard bench for fifo_ctrl driving a behavioural 16 x 9 array
module tb_fifo_ctrl;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       push  = 1'b0;
    logic       pop   = 1'b0;
    logic [8:0] wdata = '0;

    logic       mem_we, mem_re;
    logic [3:0] mem_waddr, mem_raddr;
    logic [4:0] level;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;

    fifo_ctrl #(.ADDR_W(4), .AF_LEVEL(12), .AE_LEVEL(4)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_flush        (flush),
        .i_push         (push),
        .i_pop          (pop),
        .o_mem_we       (mem_we),
        .o_mem_waddr    (mem_waddr),
        .o_mem_re       (mem_re),
        .o_mem_raddr    (mem_raddr),
        .o_level        (level),
        .o_full         (full),
        .o_empty        (empty),
        .o_almost_full  (almost_full),
        .o_almost_empty (almost_empty),
        .o_overflow     (overflow),
        .o_underflow    (underflow)
    );

    always #5 clk = ~clk;

    logic [8:0] mem [16];
    always @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= wdata;
    end

    int         n_checks = 0;
    int         n_errors = 0;
    int         m_lvl    = 0;
    logic [3:0] m_wa     = '0;
    logic [3:0] m_ra     = '0;
    logic       m_ovf    = 1'b0;
    logic       m_unf    = 1'b0;
    logic [8:0] sb [$];

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_status();
        chk("level", level, m_lvl);
        chk("full", full, (m_lvl == 16) ? 1 : 0);
        chk("empty", empty, (m_lvl == 0) ? 1 : 0);
        chk("almost_full", almost_full, (m_lvl >= 12) ? 1 : 0);
        chk("almost_empty", almost_empty, (m_lvl <= 4) ? 1 : 0);
        chk("overflow", overflow, m_ovf);
        chk("underflow", underflow, m_unf);
    endtask

    task automatic model_reset();
        m_lvl = 0;
        m_wa  = '0;
        m_ra  = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        sb.delete();
    endtask

    // Called just after a rising edge; drives one cycle and checks it before the next edge.
    task automatic step(input logic p, input logic q, input logic f, input logic [8:0] d);
        logic       e_we, e_re;
        logic [8:0] e_data;
        push  = p;
        pop   = q;
        flush = f;
        wdata = d;
        #3;
        chk_status();
        e_we = p && !f && (m_lvl < 16 || q);
        e_re = q && !f && (m_lvl > 0);
        chk("mem_we", mem_we, e_we);
        chk("mem_re", mem_re, e_re);
        chk("mem_waddr", mem_waddr, m_wa);
        chk("mem_raddr", mem_raddr, m_ra);
        if (e_re) begin
            e_data = (sb.size() > 0) ? sb.pop_front() : 9'h1FF;
            chk("rdata", mem[mem_raddr], e_data);
        end
        if (e_we) sb.push_back(d);
        @(posedge clk);
        #1;
        if (f) begin
            model_reset();
        end else begin
            if (p && !q && m_lvl == 16) m_ovf = 1'b1;
            if (q && m_lvl == 0) m_unf = 1'b1;
            m_wa  = 4'(m_wa + 4'(e_we));
            m_ra  = 4'(m_ra + 4'(e_re));
            m_lvl = m_lvl + int'(e_we) - int'(e_re);
        end
        push  = 1'b0;
        pop   = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        // Held in reset with requests asserted: enables must stay low.
        push = 1'b1;
        pop  = 1'b1;
        #3;
        chk_status();
        chk("rst_we", mem_we, 0);
        chk("rst_re", mem_re, 0);
        @(negedge clk);
        rst_n = 1'b1;
        push  = 1'b0;
        pop   = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 9'(9'h100 + i));
        chk("fill_level", level, 16);
        chk("fill_full", full, 1);
        chk("fill_no_ovf", overflow, 0);

        step(1'b1, 1'b0, 1'b0, 9'h1EE);
        chk("ovf_set", overflow, 1);
        chk("ovf_level", level, 16);

        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 9'h000);
        chk("drain_empty", empty, 1);

        step(1'b1, 1'b0, 1'b0, 9'h120);
        for (int i = 1; i < 20; i++) step(1'b1, 1'b1, 1'b0, 9'(9'h120 + i));
        step(1'b0, 1'b1, 1'b0, 9'h000);
        chk("wrap_empty", empty, 1);

        step(1'b0, 1'b0, 1'b1, 9'h000);
        chk("flush1_ovf", overflow, 0);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 9'(9'h140 + i));
        step(1'b1, 1'b1, 1'b0, 9'h15A);
        chk("pp_full_level", level, 16);
        chk("pp_full_ovf", overflow, 0);
        chk("pp_full_unf", underflow, 0);

        step(1'b0, 1'b0, 1'b1, 9'h000);
        step(1'b1, 1'b1, 1'b0, 9'h160);
        chk("pp_empty_level", level, 1);
        chk("pp_empty_unf", underflow, 1);

        step(1'b0, 1'b0, 1'b1, 9'h000);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 9'(9'h170 + i));
        step(1'b1, 1'b0, 1'b0, 9'h1EF);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 9'h000);
        chk("pre_flush_level", level, 7);
        chk("pre_flush_ovf", overflow, 1);
        step(1'b1, 1'b0, 1'b1, 9'h1FF);
        chk("flush_level", level, 0);
        chk("flush_empty", empty, 1);
        chk("flush_ovf", overflow, 0);

        // Set underflow, climb to level 9, then reset between edges while pushing.
        step(1'b0, 1'b1, 1'b0, 9'h000);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 9'(9'h180 + i));
        chk("pre_rst_level", level, 9);
        push  = 1'b1;
        wdata = 9'h1C3;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_we", mem_we, 0);
        chk("arst_level", level, 0);
        chk("arst_empty", empty, 1);
        chk("arst_ae", almost_empty, 1);
        chk("arst_full", full, 0);
        chk("arst_af", almost_full, 0);
        chk("arst_ovf", overflow, 0);
        chk("arst_unf", underflow, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        push  = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 1'b0, 9'h1A5);
        chk("post_rst_addr", mem_waddr, 1);
        step(1'b0, 1'b1, 1'b0, 9'h000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
